// File: rtl/mips_instr_profiler_pkg.sv
// Shared definitions for the MIPS instruction-mix profiler: opcode constants,
// the instruction-class enum, the decoder result struct and counter indices.
// Optional feature macro used by the profiler top: MIPS_PROF_SATURATE_EN.
package mips_prof_pkg;

  // Primary opcode field values (instruction[31:26]).
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BR_FIRST = 6'h04;  // beq
  localparam logic [5:0] OP_BR_LAST  = 6'h07;  // bgtz
  localparam logic [5:0] OP_ST_FIRST = 6'h28;  // sb
  localparam logic [5:0] OP_ST_LAST  = 6'h2B;  // sw

  // Instruction format class.
  typedef enum logic [1:0] {
    CLS_R = 2'd0,
    CLS_J = 2'd1,
    CLS_I = 2'd2
  } instr_class_t;

  // Decoder result: class plus the destination GPR, if the instruction writes one.
  typedef struct packed {
    instr_class_t cls;
    logic         dest_vld;
    logic [4:0]   dest;
  } decode_t;

  // Counter slots, shared by the readout select and the overflow vector.
  localparam int IDX_R    = 0;
  localparam int IDX_J    = 1;
  localparam int IDX_I    = 2;
  localparam int IDX_REG0 = 3;

  // I-type opcodes that never write rt: REGIMM and the classic branches, and stores.
  function automatic logic is_nonwriting_i(input logic [5:0] op);
    return (op == OP_REGIMM) ||
           ((op >= OP_BR_FIRST) && (op <= OP_BR_LAST)) ||
           ((op >= OP_ST_FIRST) && (op <= OP_ST_LAST));
  endfunction

endpackage

// File: rtl/mips_instr_profiler_if.sv
// Instruction stream handshake into the profiler.
// A word transfers on a rising edge where instr_valid and instr_ready are both
// high; the source holds instruction stable while instr_valid is high and not
// yet accepted, and instr_ready never depends combinationally on instr_valid.
interface mips_instr_profiler_if;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        instr_ready;

  modport master (
    output instr_valid,
    output instruction,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instruction,
    output instr_ready
  );
endinterface

// File: rtl/mips_instr_profiler_decode.sv
// Combinational MIPS instruction classifier: R/J/I class and the destination
// register it writes (rd for R-type, rt for writing I-types, none for J-type,
// branches, stores or a $0 destination). Has no parameters so later pipeline
// stages can reuse it unchanged.
module mips_instr_decode
  import mips_prof_pkg::*;
(
  input  logic [31:0] instruction,
  output decode_t     dec
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op = instruction[31:26];
  assign rt = instruction[20:16];
  assign rd = instruction[15:11];

  // rs, shamt/funct and immediate bits do not affect the classification.
  logic unused_fields;
  assign unused_fields = ^{instruction[25:21], instruction[10:0]};

  // Classify by primary opcode and pick the written register.
  always_comb begin
    dec.cls      = CLS_I;
    dec.dest_vld = 1'b0;
    dec.dest     = 5'd0;
    if (op == OP_SPECIAL) begin
      dec.cls      = CLS_R;
      dec.dest     = rd;
      dec.dest_vld = (rd != 5'd0);
    end else if ((op == OP_J) || (op == OP_JAL)) begin
      dec.cls      = CLS_J;
    end else begin
      dec.cls      = CLS_I;
      dec.dest     = rt;
      dec.dest_vld = !is_nonwriting_i(op) && (rt != 5'd0);
    end
  end

endmodule

// File: rtl/mips_instr_profiler.sv
// Passive instruction-mix profiler. Accepts one MIPS instruction per cycle,
// holds it for one cycle in a decode stage, then bumps the R/J/I class counter
// and, when the destination falls in REG_BASE..REG_BASE+NUM_REGS-1, that GPR's
// counter. A snapshot copies all live counters into shadows that the indexed
// readout port reads; overflow flags are sticky until clr.
// Optional feature: MIPS_PROF_SATURATE_EN -- counters hold at all-ones instead
// of wrapping to zero when incremented past their maximum.
module mips_instr_profiler
  import mips_prof_pkg::*;
#(
  parameter  int CNT_W    = 16,
  parameter  int NUM_REGS = 4,
  parameter  int REG_BASE = 3,
  localparam int NCNT     = 3 + NUM_REGS,
  localparam int SEL_W    = $clog2(3 + NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_instr_profiler_if.slave fetch,
  input  logic                 clr,
  input  logic                 snap,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [CNT_W-1:0]     rd_data,
  output logic [NCNT-1:0]      ovf
);

  logic             ready_q;
  logic             accept;
  logic             dec_vld;
  logic [31:0]      dec_instr;
  decode_t          dec;
  logic [NCNT-1:0]  inc;
  logic [CNT_W-1:0] live   [NCNT];
  logic [CNT_W-1:0] shadow [NCNT];
  logic [NCNT-1:0]  ovf_q;
  logic [CNT_W-1:0] rd_q;

  // The profiler never back-pressures, so ready simply rises one edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign fetch.instr_ready = ready_q;
  assign accept            = fetch.instr_valid && ready_q;

  // One-entry decode stage. clr does not block capture: a word accepted on the
  // clearing edge is counted on the next edge against the freshly zeroed counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_vld   <= 1'b0;
      dec_instr <= 32'd0;
    end else begin
      dec_vld <= accept;
      if (accept) begin
        dec_instr <= fetch.instruction;
      end
    end
  end

  mips_instr_decode u_decode (
    .instruction (dec_instr),
    .dec         (dec)
  );

  // Per-counter increment strobes for the instruction sitting in the decode stage.
  always_comb begin
    inc = '0;
    if (dec_vld) begin
      case (dec.cls)
        CLS_R:   inc[IDX_R] = 1'b1;
        CLS_J:   inc[IDX_J] = 1'b1;
        default: inc[IDX_I] = 1'b1;
      endcase
      for (int k = 0; k < NUM_REGS; k++) begin
        if (dec.dest_vld && (dec.dest == 5'(REG_BASE + k))) begin
          inc[IDX_REG0 + k] = 1'b1;
        end
      end
    end
  end

  // Live counters and sticky overflow flags; clr wins over any pending increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCNT; i++) begin
        live[i]  <= '0;
        ovf_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (clr) begin
          live[i]  <= '0;
          ovf_q[i] <= 1'b0;
        end else if (inc[i]) begin
          if (live[i] == {CNT_W{1'b1}}) begin
            ovf_q[i] <= 1'b1;
`ifdef MIPS_PROF_SATURATE_EN
            live[i]  <= live[i];
`else
            live[i]  <= '0;
`endif
          end else begin
            live[i] <= live[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign ovf = ovf_q;

  // Snapshot takes the live values as they stood before this edge, which makes
  // snap together with clr an atomic read-and-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCNT; i++) begin
        shadow[i] <= '0;
      end
    end else if (snap) begin
      for (int i = 0; i < NCNT; i++) begin
        shadow[i] <= live[i];
      end
    end
  end

  // Registered readout of the selected shadow; unused select codes read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (int'(rd_sel) < NCNT) begin
      rd_q <= shadow[rd_sel];
    end else begin
      rd_q <= '0;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: tb/tb_mips_instr_profiler.sv
// Bench for mips_instr_profiler. Two instances share one stimulus stream: the
// default 16-bit build and a 2-bit build that overflows quickly. The reference
// model keeps true (unbounded) event counts since the last clear and derives
// each build's visible value and overflow flag from them.
module tb_mips_instr_profiler;

  localparam int NUM_REGS = 4;
  localparam int REG_BASE = 3;
  localparam int NCNT     = 3 + NUM_REGS;
  localparam int SEL_W    = $clog2(3 + NUM_REGS);
  localparam int W_BIG    = 16;
  localparam int W_SMALL  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              instr_valid;
  logic [31:0]       instruction;
  logic              clr;
  logic              snap;
  logic [SEL_W-1:0]  rd_sel;
  logic [W_BIG-1:0]  rd_big;
  logic [W_SMALL-1:0] rd_small;
  logic [NCNT-1:0]   ovf_big;
  logic [NCNT-1:0]   ovf_small;

  mips_instr_profiler_if bus_big ();
  mips_instr_profiler_if bus_small ();

  assign bus_big.instr_valid   = instr_valid;
  assign bus_big.instruction   = instruction;
  assign bus_small.instr_valid = instr_valid;
  assign bus_small.instruction = instruction;

  mips_instr_profiler #(.CNT_W(W_BIG), .NUM_REGS(NUM_REGS), .REG_BASE(REG_BASE)) dut_big (
    .clk     (clk),
    .rst_n   (rst_n),
    .fetch   (bus_big.slave),
    .clr     (clr),
    .snap    (snap),
    .rd_sel  (rd_sel),
    .rd_data (rd_big),
    .ovf     (ovf_big)
  );

  mips_instr_profiler #(.CNT_W(W_SMALL), .NUM_REGS(NUM_REGS), .REG_BASE(REG_BASE)) dut_small (
    .clk     (clk),
    .rst_n   (rst_n),
    .fetch   (bus_small.slave),
    .clr     (clr),
    .snap    (snap),
    .rd_sel  (rd_sel),
    .rd_data (rd_small),
    .ovf     (ovf_small)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          live_m   [NCNT];
  int          shadow_m [NCNT];
  bit          pend_vld;
  logic [31:0] pend_instr;
  bit          ready_m;
  int          exp_rd_big;
  int          exp_rd_small;

  // Value a w-bit counter shows after cnt increments since clear.
  function automatic int shown(input int cnt, input int w);
    int top;
    top = (1 << w) - 1;
`ifdef MIPS_PROF_SATURATE_EN
    return (cnt > top) ? top : cnt;
`else
    return cnt % (1 << w);
`endif
  endfunction

  function automatic logic [NCNT-1:0] ovf_exp(input int w);
    logic [NCNT-1:0] v;
    v = '0;
    for (int i = 0; i < NCNT; i++) v[i] = (live_m[i] > (1 << w) - 1);
    return v;
  endfunction

  // Class index (0=R,1=J,2=I) and written GPR (-1 if none) from the MIPS rules.
  function automatic void ref_classify(input logic [31:0] w, output int cls, output int dest);
    int op;
    op = int'(w[31:26]);
    if (op == 0) begin
      cls  = 0;
      dest = int'(w[15:11]);
    end else if (op == 2 || op == 3) begin
      cls  = 1;
      dest = -1;
    end else begin
      cls = 2;
      if (op == 1 || (op >= 4 && op <= 7) || (op >= 'h28 && op <= 'h2B)) dest = -1;
      else dest = int'(w[20:16]);
    end
  endfunction

  task automatic model_count(input logic [31:0] w);
    int cls, dest;
    ref_classify(w, cls, dest);
    live_m[cls]++;
    if (dest >= REG_BASE && dest < REG_BASE + NUM_REGS && dest != 0)
      live_m[3 + dest - REG_BASE]++;
  endtask

  task automatic model_reset();
    foreach (live_m[i]) begin
      live_m[i]   = 0;
      shadow_m[i] = 0;
    end
    pend_vld     = 1'b0;
    pend_instr   = '0;
    ready_m      = 1'b0;
    exp_rd_big   = 0;
    exp_rd_small = 0;
  endtask

  // Effect of one rising edge with rst_n high, using the inputs applied before it.
  task automatic model_edge();
    bit acc;
    acc = instr_valid && ready_m;
    if (int'(rd_sel) < NCNT) begin
      exp_rd_big   = shown(shadow_m[rd_sel], W_BIG);
      exp_rd_small = shown(shadow_m[rd_sel], W_SMALL);
    end else begin
      exp_rd_big   = 0;
      exp_rd_small = 0;
    end
    if (snap) foreach (live_m[i]) shadow_m[i] = live_m[i];
    if (clr) begin
      foreach (live_m[i]) live_m[i] = 0;
    end else if (pend_vld) begin
      model_count(pend_instr);
    end
    pend_vld   = acc;
    pend_instr = instruction;
    ready_m    = 1'b1;
  endtask

  task automatic check_outputs();
    check("rd_big", 32'(rd_big), 32'(exp_rd_big));
    check("rd_small", 32'(rd_small), 32'(exp_rd_small));
    check("ovf_big", 32'(ovf_big), 32'(ovf_exp(W_BIG)));
    check("ovf_small", 32'(ovf_small), 32'(ovf_exp(W_SMALL)));
    check("ready_big", 32'(bus_big.instr_ready), 32'(ready_m));
    check("ready_small", 32'(bus_small.instr_ready), 32'(ready_m));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0;
    instruction = '0;
    clr         = 1'b0;
    snap        = 1'b0;
    rd_sel      = '0;
  endtask

  // Asynchronous reset from a falling clock edge; one idle edge after release
  // lets instr_ready come up.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("reset_rd", 32'(rd_big), 32'd0);
    check("reset_ready", 32'(bus_big.instr_ready), 32'd0);
    idle_inputs();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [31:0] w);
    instr_valid = 1'b1;
    instruction = w;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic take_snap();
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  task automatic read_sel(input int sel);
    rd_sel = SEL_W'(sel);
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0, 7:    op = 6'h00;
      1:       op = 6'($urandom_range(2, 3));
      2:       op = ($urandom_range(0, 4) == 0) ? 6'h01 : 6'($urandom_range(4, 7));
      3:       op = 6'($urandom_range('h28, 'h2B));
      4:       op = 6'h08;
      5:       op = 6'h23;
      default: op = 6'($urandom_range(0, 63));
    endcase
    return {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 9)),
            5'($urandom_range(0, 9)), 11'($urandom_range(0, 2047))};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    #1;
    do_reset();

    // add $3,$4,$5 -> R=1, GPR3=1, J=I=0
    send(32'h00851820);
    step();
    take_snap();
    read_sel(0); check("add_R", 32'(rd_big), 32'd1);
    read_sel(3); check("add_GPR3", 32'(rd_big), 32'd1);
    read_sel(1); check("add_J", 32'(rd_big), 32'd0);
    read_sel(2); check("add_I", 32'(rd_big), 32'd0);

    // j / addi $4 / sw $5 back-to-back
    instr_valid = 1'b1;
    instruction = 32'h08000000; step();
    instruction = 32'h20040001; step();
    instruction = 32'hAC050000; step();
    instr_valid = 1'b0;
    step();
    take_snap();
    read_sel(1); check("mix_J", 32'(rd_big), 32'd1);
    read_sel(2); check("mix_I", 32'(rd_big), 32'd2);
    read_sel(4); check("mix_GPR4", 32'(rd_big), 32'd1);
    read_sel(5); check("mix_GPR5", 32'(rd_big), 32'd0);

    // five adds to $6, then read-and-clear
    instr_valid = 1'b1;
    instruction = 32'h00853020;
    repeat (5) step();
    instr_valid = 1'b0;
    step();
    clr  = 1'b1;
    snap = 1'b1;
    step();
    clr  = 1'b0;
    snap = 1'b0;
    read_sel(6); check("rac_GPR6", 32'(rd_big), 32'd5);
    check("rac_ovf", 32'(ovf_big), 32'd0);
    take_snap();
    read_sel(6); check("rac_GPR6_after", 32'(rd_big), 32'd0);

    // four R-types overflow the 2-bit build
    instr_valid = 1'b1;
    instruction = 32'h00851820;
    repeat (4) step();
    instr_valid = 1'b0;
    step();
    take_snap();
    read_sel(0);
    check("ovf_big_R", 32'(rd_big), 32'd4);
`ifdef MIPS_PROF_SATURATE_EN
    check("ovf_small_R", 32'(rd_small), 32'd3);
`else
    check("ovf_small_R", 32'(rd_small), 32'd0);
`endif
    check("ovf_small_flag", 32'(ovf_small[0]), 32'd1);

    // out-of-range select reads zero
    read_sel(NCNT);
    check("sel_oob_big", 32'(rd_big), 32'd0);
    check("sel_oob_small", 32'(rd_small), 32'd0);

    // reset with an instruction in the decode stage: it must be lost
    send(32'h00851820);
    do_reset();
    step();
    take_snap();
    read_sel(0); check("rst_R", 32'(rd_big), 32'd0);
    read_sel(3); check("rst_GPR3", 32'(rd_big), 32'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      instruction = rand_instr();
      clr         = ($urandom_range(0, 29) == 0);
      snap        = ($urandom_range(0, 3) == 0);
      rd_sel      = SEL_W'($urandom_range(0, NCNT));
      step();
      if (i == 400) do_reset();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_instr_profiler.md
# mips_instr_profiler

Parametrised successor to the instruction-mix counter in the assignment-7 processor work. Consumes a stream of 32-bit MIPS instructions over a valid/ready handshake, classifies each as R/J/I type and counts destination-register writes for a configurable window of GPRs. Adds what the earlier counter lacked: async reset, synchronous clear, an atomic snapshot into shadow registers, an indexed readout port, sticky overflow flags, and exclusion of non-writing I-types from register counts. Sits beside the fetch/decode stage as a passive profiling monitor.

## Interface
- CNT_W, 16: width of every counter, >=2
- NUM_REGS, 4: number of tracked destination GPRs, 1..31
- REG_BASE, 3: lowest tracked GPR number; tracks REG_BASE..REG_BASE+NUM_REGS-1; REG_BASE>=1 and REG_BASE+NUM_REGS<=32
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instruction  in  32  MIPS instruction word
- instr_ready  out  1  block accepts; registered
- clr  in  1  synchronous clear of live counters and ovf
- snap  in  1  copy live counters to shadow
- rd_sel  in  $clog2(3+NUM_REGS)  counter index: 0=R, 1=J, 2=I, 3+k=GPR REG_BASE+k
- rd_data  out  CNT_W  shadow counter value, registered
- ovf  out  3+NUM_REGS  sticky per-counter overflow, same indexing as rd_sel

## Operation
- Accept when instr_valid && instr_ready at a rising edge; instruction captured into a one-entry decode stage.
- Classification: opcode[31:26]==0 -> R, dest = rd[15:11]; opcode 2 or 3 -> J, no dest; all else -> I, dest = rt[20:16].
- I-types with opcode 1, 4-7 (branches) or 0x28-0x2B (stores) increment I but no register counter.
- GPR counter k increments when dest == REG_BASE+k; GPR 0 never counted.
- Counter update happens at the edge after capture (decode stage -> live counters).
- snap: shadow[i] <= live[i] for all i at the same edge, values from before that edge's update.
- rd_data <= (rd_sel < 3+NUM_REGS) ? shadow[rd_sel] : 0 every cycle.
- instr_ready: 0 during reset, 1 from first edge after rst_n deasserts, 1 thereafter.

## Timing
- Reset values: all live counters, shadows, decode-stage valid, rd_data, ovf = 0; instr_ready = 0.
- Accept at edge N -> live counter updated at edge N+1 -> visible after snap at edge >=N+1 -> rd_data one edge after snap/select.
- Throughput: one instruction per cycle, back-to-back.
- clr at edge E: live counters and ovf zeroed; instruction in decode stage at E discarded; instruction accepted at E counts at E+1.
- clr and snap same edge: shadow receives pre-clear values (read-and-clear).
- Overflow: increment at all-ones sets ovf[i]; counter behaviour per Configuration.
- rst_n asserted mid-stream: immediate return to reset values; in-flight instruction lost.

## Configuration
- MIPS_PROF_SATURATE_EN defined: counters hold at 2^CNT_W-1 on overflow; ovf[i] set.
- Undefined: counters wrap to 0 on overflow; ovf[i] set.

## Structure
- Package mips_prof_pkg: opcode constants (SPECIAL, J, JAL, REGIMM, branch and store ranges), instr-class enum, counter index constants IDX_R/IDX_J/IDX_I/IDX_REG0.
- Sub-module mips_instr_decode: combinational classifier, instruction -> {class, dest_vld, dest}; parametrised by nothing, reused by later pipeline work.

## Test plan
- Reset, then 0x00851820 (add $3,$4,$5), snap, rd_sel=0 and 3 -> R=1, GPR3=1; J=I=0.
- 0x08000000 (j), 0x20040001 (addi $4), 0xAC050000 (sw $5) back-to-back, snap -> J=1, I=2, GPR4=1, GPR5=0.
- clr and snap same edge after 5 adds to $6 -> shadow GPR6=5; next snap -> 0; ovf=0.
- CNT_W=2, 4 R-types -> R=3 and ovf[0]=1 with MIPS_PROF_SATURATE_EN; R=0 and ovf[0]=1 without.
- rst_n pulsed low with instruction in decode stage -> all outputs 0, instr_ready 0; instruction not counted after release.
- rd_sel=3+NUM_REGS -> rd_data=0 next cycle.
